mmc_latch_mapper: RTL and testbench
===================================

Name: mmc_latch_mapper

Overview:
- Parametrised successor to the MMC2/MMC4 CHR-latch mappers: one block covering both chips, selected at runtime by `mode_mmc4`.
- Generalised PRG/CHR bank widths and address bases.
- Deferred latch update: the bank switches after the triggering PPU fetch completes, matching hardware.
- Plain outputs; the mapper-bus wrapper adds the `enable`-gated tristates.

Parameters:
- PRG_BANK_W, 4: PRG bank register width. 8 KB units in MMC2 mode, 16 KB units in MMC4 mode.
- CHR_BANK_W, 5: CHR bank register width, 4 KB units.
- CHR_BASE, 22'h200000: OR'd base for CHR output addresses.
- PRG_RAM_BASE, 22'h3C0000: base for the 8 KB PRG-RAM window (MMC4 mode only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  mapper selected; low holds all registers at reset values
- ce  in  1  CPU-cycle enable (M2)
- mode_mmc4  in  1  0 = MMC2, 1 = MMC4; static while enable is high
- prg_ain  in  16  CPU address
- prg_write  in  1  CPU write strobe
- prg_din  in  8  CPU write data
- prg_aout  out  22  PRG memory address
- prg_allow  out  1  PRG access permitted
- chr_ain  in  14  PPU address (combinational mapping)
- chr_ain_o  in  14  PPU address used for latch trigger detection
- chr_read  in  1  PPU read strobe
- paused  in  1  freeze latch logic
- chr_ram_en  in  1  cart has CHR-RAM (flags[15])
- chr_aout  out  22  CHR memory address
- chr_allow  out  1  CHR write permitted
- vram_a10  out  1  nametable A10
- vram_ce  out  1  route to internal VRAM
- latch_state  out  2  {latch1, latch0}; 0 = $FD, 1 = $FE
- ss_load  in  1  load state from ss_din
- ss_din  in  64  savestate in
- ss_dout  out  64  savestate out

Behaviour:
- Reset (rst_n low, async) and enable low both clear:
  - prg_bank, chr_0a, chr_0b, chr_1a, chr_1b, mirroring
  - latch0 = latch1 = 0
  - pend_v[1:0] = 0
- Priority each clk: reset > enable low > ss_load > register/latch updates.
- Register writes occur when ce & prg_write & prg_ain[15], decoded on prg_ain[14:12]:
  - 2: prg_bank ← din[PRG_BANK_W-1:0]
  - 3: chr_0a ← din[CHR_BANK_W-1:0]
  - 4: chr_0b
  - 5: chr_1a
  - 6: chr_1b
  - 7: mirroring ← din[0]
  - 0, 1: ignored
- Registers take effect on the next clk.
- Latch triggers are evaluated when chr_read & ~paused:
  - latch0 FD trigger: MMC2 mode requires chr_ain_o == $0FD8 exactly; MMC4 mode matches (chr_ain_o & $3FF8) == $0FD8.
  - latch0 FE trigger: same rule, with $0FE8.
  - latch1 uses the $1FD8/$1FE8 range match in both modes.
  - A match sets pend_v[i] = 1 and pend_val[i] (FD → 0, FE → 1).
  - A later match on the same latch while pending overwrites pend_val.
- Latch apply:
  - On the first clk with chr_read = 0 and ~paused, latch[i] ← pend_val[i] for each i with pend_v[i], and pend_v[i] clears.
  - The triggering fetch therefore uses the old bank; the switch latency is one clk after chr_read falls.
  - A match and an apply can never occur in the same cycle.
- paused freezes both pending and latch state.
- ss_load loads the bank registers and latches as laid out under Savestate, and clears pend_v.
- PRG mapping in MMC2 mode:
  - $8000–$9FFF → prg_bank.
  - $A000–$FFFF → {ones(PRG_BANK_W-2), prg_ain[14:13]}.
  - prg_aout = {0, sel, prg_ain[12:0]}.
  - prg_allow = prg_ain[15] & ~prg_write.
- PRG mapping in MMC4 mode:
  - $8000–$BFFF → prg_bank.
  - $C000–$FFFF → all-ones bank.
  - prg_aout = {0, sel, prg_ain[13:0]}.
  - $6000–$7FFF → PRG_RAM_BASE | prg_ain[12:0]; prg_allow = 1 for read and write there.
- CHR mapping:
  - chr_ain[12] = 0 selects latch0 ? chr_0b : chr_0a.
  - chr_ain[12] = 1 selects latch1 ? chr_1b : chr_1a.
  - chr_aout = CHR_BASE | {sel, chr_ain[11:0]}.
- Other outputs:
  - vram_a10 = mirroring ? chr_ain[11] : chr_ain[10].
  - vram_ce = chr_ain[13].
  - chr_allow = chr_ram_en.
- Savestate layout (same bits for ss_din and ss_dout):
  - [7:0] prg_bank, zero-extended.
  - [15:8], [23:16], [31:24], [39:32] chr_0a, chr_0b, chr_1a, chr_1b.
  - [40] mirroring, [41] latch0, [42] latch1.
  - Remaining bits zero.
  - ss_dout = 0 when enable is low.
- Width rule: PRG_BANK_W ≤ 8 and CHR_BANK_W ≤ 8; this is an elaboration-time check.

Decomposition:
- Package `mmc_latch_pkg` holds:
  - Trigger address constants $0FD8, $0FE8, $1FD8, $1FE8 and the range mask $3FF8.
  - Register index enum (PRG = 2 … MIRR = 7).
  - Savestate field offsets.
- Sub-module `mmc_chr_latch`, instantiated twice. Contains the trigger compare, the pending register and the apply logic, plus an `exact_match` input (tied to ~mode_mmc4 for latch0, 0 for latch1).

Test Plan:
- rst_n low mid-pending (pend_v = 1) → latch_state = 0 and pend_v = 0 immediately; after release, chr_ain = $0123 → chr_aout = CHR_BASE | $0123 (chr_0a = 0).
- MMC2 mode, write $B000 = $03, $C000 = $07; read $0FE8 for 2 clks → chr_aout keeps bank 3 during the read; one clk after chr_read falls, latch0 = 1 and chr_ain = $0000 maps to CHR_BASE | $7000.
- MMC2 mode, read $0FE9 → latch0 unchanged; MMC4 mode, read $0FE9 → latch0 = 1 after the read ends.
- MMC4 mode, $A000 = $05; prg_ain = $9234 → prg_aout = $15234; $C000 → $3C000; write to $6010 → prg_aout = $3C0010 and prg_allow = 1; same write in MMC2 mode → prg_allow = 0.
- MMC2 mode, $A000 = $02: $8000 → $04000, $A000 → $1A000, $E000 → $1E000; $F000 = 1 with chr_ain = $2800 → vram_a10 = 1, vram_ce = 1.
- With paused = 1, read $1FD8 → no latch change; ss_load with ss_din[42] = 1 → latch1 = 1 and pending cleared; ss_dout round-trips all fields and reads 0 when enable = 0.

Source files
------------

// File: rtl/mmc_latch_pkg.sv
// Shared constants for the MMC2/MMC4 CHR-latch mapper: latch trigger
// addresses, register index decode and savestate field positions.
package mmc_latch_pkg;

    // PPU fetch addresses that arm the CHR latches
    localparam logic [13:0] TRIG_L0_FD = 14'h0FD8;
    localparam logic [13:0] TRIG_L0_FE = 14'h0FE8;
    localparam logic [13:0] TRIG_L1_FD = 14'h1FD8;
    localparam logic [13:0] TRIG_L1_FE = 14'h1FE8;
    // Range match ignores the low three address bits ($xFD8-$xFDF)
    localparam logic [13:0] TRIG_MASK  = 14'h3FF8;

    // Register index taken from CPU address bits [14:12]; 0 and 1 are unused
    typedef enum logic [2:0] {
        REG_PRG    = 3'd2,
        REG_CHR_0A = 3'd3,
        REG_CHR_0B = 3'd4,
        REG_CHR_1A = 3'd5,
        REG_CHR_1B = 3'd6,
        REG_MIRR   = 3'd7
    } reg_idx_e;

    // Savestate word layout, shared by load and dump
    localparam int SS_PRG_LSB    = 0;
    localparam int SS_CHR_0A_LSB = 8;
    localparam int SS_CHR_0B_LSB = 16;
    localparam int SS_CHR_1A_LSB = 24;
    localparam int SS_CHR_1B_LSB = 32;
    localparam int SS_MIRR_BIT   = 40;
    localparam int SS_LATCH0_BIT = 41;
    localparam int SS_LATCH1_BIT = 42;

    // Exact compare (MMC2 latch0) or 8-byte range compare (everything else)
    function automatic logic trig_hit(input logic [13:0] addr,
                                      input logic [13:0] target,
                                      input logic        exact);
        return exact ? (addr == target) : ((addr & TRIG_MASK) == target);
    endfunction

endpackage

// File: rtl/mmc_chr_latch.sv
// One CHR latch: detects the $xFD/$xFE trigger fetch, holds the new value
// as pending while the fetch is still in progress, and commits it on the
// first cycle the PPU read strobe is low so the triggering fetch still sees
// the old bank.
module mmc_chr_latch
    import mmc_latch_pkg::*;
#(
    parameter logic [13:0] FD_ADDR = TRIG_L0_FD,
    parameter logic [13:0] FE_ADDR = TRIG_L0_FE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        ss_load,
    input  logic        ss_latch,
    input  logic        chr_read,
    input  logic        paused,
    input  logic [13:0] trig_addr,
    input  logic        exact_match,
    output logic        latch
);

    logic hit_fd;
    logic hit_fe;
    logic pend_v;
    logic pend_val;

    assign hit_fd = trig_hit(trig_addr, FD_ADDR, exact_match);
    assign hit_fe = trig_hit(trig_addr, FE_ADDR, exact_match);

    // Arm on a matching fetch, commit once the read strobe drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch    <= 1'b0;
            pend_v   <= 1'b0;
            pend_val <= 1'b0;
        end else if (clr) begin
            latch  <= 1'b0;
            pend_v <= 1'b0;
        end else if (ss_load) begin
            latch  <= ss_latch;
            pend_v <= 1'b0;
        end else if (!paused) begin
            if (chr_read) begin
                if (hit_fd) begin
                    pend_v   <= 1'b1;
                    pend_val <= 1'b0;
                end else if (hit_fe) begin
                    pend_v   <= 1'b1;
                    pend_val <= 1'b1;
                end
            end else if (pend_v) begin
                latch  <= pend_val;
                pend_v <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmc_latch_mapper.sv
// MMC2/MMC4 CHR-latch mapper core. Chip personality is chosen by mode_mmc4.
// Outputs are plain; bus tristating is done by the surrounding wrapper.
module mmc_latch_mapper
    import mmc_latch_pkg::*;
#(
    parameter int          PRG_BANK_W   = 4,
    parameter int          CHR_BANK_W   = 5,
    parameter logic [21:0] CHR_BASE     = 22'h200000,
    parameter logic [21:0] PRG_RAM_BASE = 22'h3C0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        ce,
    input  logic        mode_mmc4,
    input  logic [15:0] prg_ain,
    input  logic        prg_write,
    input  logic [7:0]  prg_din,
    output logic [21:0] prg_aout,
    output logic        prg_allow,
    input  logic [13:0] chr_ain,
    input  logic [13:0] chr_ain_o,
    input  logic        chr_read,
    input  logic        paused,
    input  logic        chr_ram_en,
    output logic [21:0] chr_aout,
    output logic        chr_allow,
    output logic        vram_a10,
    output logic        vram_ce,
    output logic [1:0]  latch_state,
    input  logic        ss_load,
    input  logic [63:0] ss_din,
    output logic [63:0] ss_dout
);

    // Bank fields must fit their byte-wide savestate slots; MMC2 fixed banks
    // need at least two bank bits.
    if (PRG_BANK_W < 2 || PRG_BANK_W > 8 || CHR_BANK_W < 1 || CHR_BANK_W > 8) begin : g_bad_width
        $error("mmc_latch_mapper: PRG_BANK_W must be 2..8 and CHR_BANK_W 1..8");
    end

    logic [PRG_BANK_W-1:0] prg_bank;
    logic [CHR_BANK_W-1:0] chr_0a;
    logic [CHR_BANK_W-1:0] chr_0b;
    logic [CHR_BANK_W-1:0] chr_1a;
    logic [CHR_BANK_W-1:0] chr_1b;
    logic                  mirroring;
    logic                  latch0;
    logic                  latch1;
    logic                  reg_wr;
    logic [PRG_BANK_W-1:0] prg_sel;
    logic [CHR_BANK_W-1:0] chr_sel;
    logic                  unused_bits;

    assign reg_wr = ce & prg_write & prg_ain[15];

    // Input bits the mapping never consumes (high data bits, spare savestate bits)
    assign unused_bits = ^{prg_din, ss_din};

    // Bank and mirroring registers: reset > disable > savestate > CPU write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prg_bank  <= '0;
            chr_0a    <= '0;
            chr_0b    <= '0;
            chr_1a    <= '0;
            chr_1b    <= '0;
            mirroring <= 1'b0;
        end else if (!enable) begin
            prg_bank  <= '0;
            chr_0a    <= '0;
            chr_0b    <= '0;
            chr_1a    <= '0;
            chr_1b    <= '0;
            mirroring <= 1'b0;
        end else if (ss_load) begin
            prg_bank  <= ss_din[SS_PRG_LSB    +: PRG_BANK_W];
            chr_0a    <= ss_din[SS_CHR_0A_LSB +: CHR_BANK_W];
            chr_0b    <= ss_din[SS_CHR_0B_LSB +: CHR_BANK_W];
            chr_1a    <= ss_din[SS_CHR_1A_LSB +: CHR_BANK_W];
            chr_1b    <= ss_din[SS_CHR_1B_LSB +: CHR_BANK_W];
            mirroring <= ss_din[SS_MIRR_BIT];
        end else if (reg_wr) begin
            case (prg_ain[14:12])
                REG_PRG:    prg_bank  <= prg_din[PRG_BANK_W-1:0];
                REG_CHR_0A: chr_0a    <= prg_din[CHR_BANK_W-1:0];
                REG_CHR_0B: chr_0b    <= prg_din[CHR_BANK_W-1:0];
                REG_CHR_1A: chr_1a    <= prg_din[CHR_BANK_W-1:0];
                REG_CHR_1B: chr_1b    <= prg_din[CHR_BANK_W-1:0];
                REG_MIRR:   mirroring <= prg_din[0];
                default:    ;
            endcase
        end
    end

    // Latch0 is an exact match on MMC2, a range match on MMC4
    mmc_chr_latch #(
        .FD_ADDR (TRIG_L0_FD),
        .FE_ADDR (TRIG_L0_FE)
    ) u_latch0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (~enable),
        .ss_load     (ss_load),
        .ss_latch    (ss_din[SS_LATCH0_BIT]),
        .chr_read    (chr_read),
        .paused      (paused),
        .trig_addr   (chr_ain_o),
        .exact_match (~mode_mmc4),
        .latch       (latch0)
    );

    // Latch1 always uses the range match
    mmc_chr_latch #(
        .FD_ADDR (TRIG_L1_FD),
        .FE_ADDR (TRIG_L1_FE)
    ) u_latch1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (~enable),
        .ss_load     (ss_load),
        .ss_latch    (ss_din[SS_LATCH1_BIT]),
        .chr_read    (chr_read),
        .paused      (paused),
        .trig_addr   (chr_ain_o),
        .exact_match (1'b0),
        .latch       (latch1)
    );

    assign latch_state = {latch1, latch0};

    // PRG window: 8 KB switchable + three fixed banks (MMC2) or
    // 16 KB switchable + fixed last bank + PRG-RAM (MMC4)
    always_comb begin
        prg_sel   = '1;
        prg_aout  = '0;
        prg_allow = prg_ain[15] & ~prg_write;
        if (mode_mmc4) begin
            if (prg_ain[15:13] == 3'b011) begin
                prg_aout  = PRG_RAM_BASE | 22'(prg_ain[12:0]);
                prg_allow = 1'b1;
            end else begin
                if (prg_ain[15:14] == 2'b10) begin
                    prg_sel = prg_bank;
                end
                prg_aout = (22'(prg_sel) << 14) | 22'(prg_ain[13:0]);
            end
        end else begin
            if (prg_ain[15:13] == 3'b100) begin
                prg_sel = prg_bank;
            end else begin
                prg_sel[1:0] = prg_ain[14:13];
            end
            prg_aout = (22'(prg_sel) << 13) | 22'(prg_ain[12:0]);
        end
    end

    // CHR window: each 4 KB half picks its bank through its own latch
    always_comb begin
        if (chr_ain[12]) begin
            chr_sel = latch1 ? chr_1b : chr_1a;
        end else begin
            chr_sel = latch0 ? chr_0b : chr_0a;
        end
        chr_aout = CHR_BASE | (22'(chr_sel) << 12) | 22'(chr_ain[11:0]);
    end

    assign vram_a10  = mirroring ? chr_ain[11] : chr_ain[10];
    assign vram_ce   = chr_ain[13];
    assign chr_allow = chr_ram_en;

    // Savestate dump; reads zero while the mapper is deselected
    always_comb begin
        ss_dout = '0;
        if (enable) begin
            ss_dout[SS_PRG_LSB    +: PRG_BANK_W] = prg_bank;
            ss_dout[SS_CHR_0A_LSB +: CHR_BANK_W] = chr_0a;
            ss_dout[SS_CHR_0B_LSB +: CHR_BANK_W] = chr_0b;
            ss_dout[SS_CHR_1A_LSB +: CHR_BANK_W] = chr_1a;
            ss_dout[SS_CHR_1B_LSB +: CHR_BANK_W] = chr_1b;
            ss_dout[SS_MIRR_BIT]                 = mirroring;
            ss_dout[SS_LATCH0_BIT]               = latch0;
            ss_dout[SS_LATCH1_BIT]               = latch1;
        end
    end

endmodule

// File: tb/tb_mmc_latch_mapper.sv
// Bench for mmc_latch_mapper: directed scenarios followed by randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_mmc_latch_mapper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        ce;
    logic        mode_mmc4;
    logic [15:0] prg_ain;
    logic        prg_write;
    logic [7:0]  prg_din;
    logic [21:0] prg_aout;
    logic        prg_allow;
    logic [13:0] chr_ain;
    logic [13:0] chr_ain_o;
    logic        chr_read;
    logic        paused;
    logic        chr_ram_en;
    logic [21:0] chr_aout;
    logic        chr_allow;
    logic        vram_a10;
    logic        vram_ce;
    logic [1:0]  latch_state;
    logic        ss_load;
    logic [63:0] ss_din;
    logic [63:0] ss_dout;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_prg;
    int m_chr [4];
    int m_mirr;
    int m_latch [2];
    int m_pv [2];
    int m_pval [2];

    int trig_list [4] = '{'h0FD8, 'h0FE8, 'h1FD8, 'h1FE8};

    always #5 clk = ~clk;

    mmc_latch_mapper dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .ce          (ce),
        .mode_mmc4   (mode_mmc4),
        .prg_ain     (prg_ain),
        .prg_write   (prg_write),
        .prg_din     (prg_din),
        .prg_aout    (prg_aout),
        .prg_allow   (prg_allow),
        .chr_ain     (chr_ain),
        .chr_ain_o   (chr_ain_o),
        .chr_read    (chr_read),
        .paused      (paused),
        .chr_ram_en  (chr_ram_en),
        .chr_aout    (chr_aout),
        .chr_allow   (chr_allow),
        .vram_a10    (vram_a10),
        .vram_ce     (vram_ce),
        .latch_state (latch_state),
        .ss_load     (ss_load),
        .ss_din      (ss_din),
        .ss_dout     (ss_dout)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_prg  = 0;
        m_mirr = 0;
        for (int i = 0; i < 4; i++) m_chr[i] = 0;
        for (int i = 0; i < 2; i++) begin
            m_latch[i] = 0;
            m_pv[i]    = 0;
        end
    endtask

    // -1 = no trigger, 0 = $FD trigger, 1 = $FE trigger
    function automatic int trig(int i, int a);
        int fd;
        int al;
        fd = (i == 0) ? 'h0FD8 : 'h1FD8;
        al = (i == 0 && !mode_mmc4) ? a : a - (a % 8);
        if (al == fd) return 0;
        if (al == fd + 'h10) return 1;
        return -1;
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        int a;
        int idx;
        int t;
        a = int'(prg_ain);
        if (!enable) begin
            model_clear();
        end else if (ss_load) begin
            m_prg    = int'(ss_din[7:0]) % 16;
            m_chr[0] = int'(ss_din[15:8]) % 32;
            m_chr[1] = int'(ss_din[23:16]) % 32;
            m_chr[2] = int'(ss_din[31:24]) % 32;
            m_chr[3] = int'(ss_din[39:32]) % 32;
            m_mirr   = int'(ss_din[40]);
            m_latch[0] = int'(ss_din[41]);
            m_latch[1] = int'(ss_din[42]);
            m_pv[0] = 0;
            m_pv[1] = 0;
        end else begin
            if (ce && prg_write && a >= 'h8000) begin
                idx = (a / 4096) % 8;
                if (idx == 2) m_prg = int'(prg_din) % 16;
                else if (idx >= 3 && idx <= 6) m_chr[idx-3] = int'(prg_din) % 32;
                else if (idx == 7) m_mirr = int'(prg_din) % 2;
            end
            if (!paused) begin
                for (int i = 0; i < 2; i++) begin
                    if (chr_read) begin
                        t = trig(i, int'(chr_ain_o));
                        if (t >= 0) begin
                            m_pv[i]   = 1;
                            m_pval[i] = t;
                        end
                    end else if (m_pv[i] != 0) begin
                        m_latch[i] = m_pval[i];
                        m_pv[i]    = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [15:0] addr, logic [7:0] data);
        prg_ain   = addr;
        prg_din   = data;
        prg_write = 1'b1;
        ce        = 1'b1;
        tick();
        prg_write = 1'b0;
        ce        = 1'b0;
    endtask

    task automatic check_outputs(string tag);
        int a;
        int c;
        int bank;
        longint e_prg;
        longint e_ss;
        bit e_allow;
        a = int'(prg_ain);
        c = int'(chr_ain);
        if (mode_mmc4) begin
            if (a >= 'h6000 && a < 'h8000) begin
                e_prg = 'h3C0000 + (a % 8192);
            end else begin
                bank  = (a >= 'h8000 && a < 'hC000) ? m_prg : 15;
                e_prg = bank * 16384 + (a % 16384);
            end
        end else begin
            bank  = (a >= 'h8000 && a < 'hA000) ? m_prg : 12 + ((a / 8192) % 4);
            e_prg = bank * 8192 + (a % 8192);
        end
        e_allow = (mode_mmc4 && a >= 'h6000 && a < 'h8000) ? 1'b1 : (a >= 'h8000 && !prg_write);
        if ((c / 4096) % 2 == 1) bank = (m_latch[1] != 0) ? m_chr[3] : m_chr[2];
        else                     bank = (m_latch[0] != 0) ? m_chr[1] : m_chr[0];
        e_ss = 0;
        if (enable) begin
            e_ss = longint'(m_prg) + (longint'(m_chr[0]) << 8) + (longint'(m_chr[1]) << 16)
                 + (longint'(m_chr[2]) << 24) + (longint'(m_chr[3]) << 32)
                 + (longint'(m_mirr) << 40) + (longint'(m_latch[0]) << 41)
                 + (longint'(m_latch[1]) << 42);
        end
        check({tag, ".prg_aout"},  64'(prg_aout),    64'(e_prg));
        check({tag, ".prg_allow"}, 64'(prg_allow),   64'(e_allow));
        check({tag, ".chr_aout"},  64'(chr_aout),    64'('h200000 + bank * 4096 + (c % 4096)));
        check({tag, ".chr_allow"}, 64'(chr_allow),   64'(chr_ram_en));
        check({tag, ".vram_a10"},  64'(vram_a10),    64'((m_mirr != 0) ? (c / 2048) % 2 : (c / 1024) % 2));
        check({tag, ".vram_ce"},   64'(vram_ce),     64'((c / 8192) % 2));
        check({tag, ".latch"},     64'(latch_state), 64'(m_latch[1] * 2 + m_latch[0]));
        check({tag, ".ss_dout"},   ss_dout,          64'(e_ss));
    endtask

    task automatic set_mode(logic m);
        enable = 1'b0;
        tick();
        mode_mmc4 = m;
        enable    = 1'b1;
        tick();
    endtask

    task automatic chr_fetch(logic [13:0] a, int n);
        chr_ain   = a;
        chr_ain_o = a;
        chr_read  = 1'b1;
        for (int i = 0; i < n; i++) tick();
        chr_read = 1'b0;
        tick();
    endtask

    logic [63:0] ss_val;

    initial begin
        rst_n = 1'b0; enable = 1'b0; ce = 1'b0; mode_mmc4 = 1'b0;
        prg_ain = '0; prg_write = 1'b0; prg_din = '0;
        chr_ain = '0; chr_ain_o = '0; chr_read = 1'b0; paused = 1'b0;
        chr_ram_en = 1'b0; ss_load = 1'b0; ss_din = '0;
        model_clear();
        m_pval[0] = 0;
        m_pval[1] = 0;

        #12;
        check("reset.latch", 64'(latch_state), 64'd0);
        check("reset.ss_dout_dis", ss_dout, 64'd0);
        check_outputs("reset");
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

        // Reset while latch0 has an $FE trigger pending
        chr_ain_o = 14'h0FE8;
        chr_read  = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_mid.latch", 64'(latch_state), 64'd0);
        chr_read = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        tick();
        check("rst_mid.no_apply", 64'(latch_state), 64'd0);
        chr_ain = 14'h0123;
        #1;
        check("rst_mid.chr_aout", 64'(chr_aout), 64'h200123);
        check_outputs("rst_mid");

        // MMC2: deferred latch0 switch from bank 3 to bank 7
        wr(16'hB000, 8'h03);
        wr(16'hC000, 8'h07);
        chr_ain   = 14'h0FE8;
        chr_ain_o = 14'h0FE8;
        chr_read  = 1'b1;
        tick();
        check("defer.during1", 64'(chr_aout), 64'h203FE8);
        tick();
        check("defer.during2", 64'(chr_aout), 64'h203FE8);
        chr_read = 1'b0;
        #1;
        check("defer.fall", 64'(latch_state), 64'd0);
        tick();
        check("defer.applied", 64'(latch_state), 64'd1);
        chr_ain = 14'h0000;
        #1;
        check("defer.bank7", 64'(chr_aout), 64'h207000);
        check_outputs("defer");

        // Exact versus range match for latch0
        chr_fetch(14'h0FD8, 1);
        check("mmc2.fd", 64'(latch_state), 64'd0);
        chr_fetch(14'h0FE9, 2);
        check("mmc2.fe9_ignored", 64'(latch_state), 64'd0);
        set_mode(1'b1);
        chr_fetch(14'h0FE9, 2);
        check("mmc4.fe9_range", 64'(latch_state), 64'd1);
        check_outputs("mmc4.latch");

        // MMC4 PRG mapping and PRG-RAM window
        wr(16'hA000, 8'h05);
        prg_ain = 16'h9234;
        #1;
        check("mmc4.prg_9234", 64'(prg_aout), 64'h15234);
        prg_ain = 16'hC000;
        #1;
        check("mmc4.prg_c000", 64'(prg_aout), 64'h3C000);
        prg_ain   = 16'h6010;
        prg_write = 1'b1;
        #1;
        check("mmc4.ram_addr", 64'(prg_aout), 64'h3C0010);
        check("mmc4.ram_allow", 64'(prg_allow), 64'd1);
        check_outputs("mmc4.prg");
        prg_write = 1'b0;
        set_mode(1'b0);
        prg_ain   = 16'h6010;
        prg_write = 1'b1;
        #1;
        check("mmc2.ram_allow", 64'(prg_allow), 64'd0);
        prg_write = 1'b0;

        // MMC2 PRG mapping and mirroring
        wr(16'hA000, 8'h02);
        prg_ain = 16'h8000;
        #1;
        check("mmc2.prg_8000", 64'(prg_aout), 64'h04000);
        prg_ain = 16'hA000;
        #1;
        check("mmc2.prg_a000", 64'(prg_aout), 64'h1A000);
        prg_ain = 16'hE000;
        #1;
        check("mmc2.prg_e000", 64'(prg_aout), 64'h1E000);
        wr(16'hF000, 8'h01);
        chr_ain = 14'h2800;
        #1;
        check("mirr.a10", 64'(vram_a10), 64'd1);
        check("mirr.vram_ce", 64'(vram_ce), 64'd1);
        check_outputs("mirr");

        // Pause freezes trigger detection; savestate load clears pending
        chr_fetch(14'h1FE8, 1);
        check("l1.set", 64'(latch_state), 64'd2);
        paused = 1'b1;
        chr_fetch(14'h1FD8, 2);
        tick();
        paused = 1'b0;
        tick();
        check("pause.frozen", 64'(latch_state), 64'd2);
        chr_ain_o = 14'h1FD8;
        chr_read  = 1'b1;
        tick();
        chr_read = 1'b0;
        ss_val = {21'h0, 1'b1, 1'b0, 1'b1, 8'h09, 8'h1F, 8'h02, 8'h11, 8'h0B};
        ss_din  = ss_val;
        ss_load = 1'b1;
        tick();
        ss_load = 1'b0;
        tick();
        check("ss.latch", 64'(latch_state), 64'd2);
        check("ss.roundtrip", ss_dout, ss_val);
        check_outputs("ss");
        enable = 1'b0;
        #1;
        check("ss.disabled", ss_dout, 64'd0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (!enable) begin
                mode_mmc4 = 1'($urandom_range(0, 1));
                enable    = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                enable = 1'b0;
            end
            ce        = 1'($urandom_range(0, 1));
            prg_write = ($urandom_range(0, 2) == 0);
            prg_ain   = 16'($urandom);
            prg_din   = 8'($urandom);
            chr_ain   = 14'($urandom);
            if ($urandom_range(0, 4) == 0) chr_ain_o = 14'($urandom);
            else chr_ain_o = 14'(trig_list[$urandom_range(0, 3)] + $urandom_range(0, 9));
            if ($urandom_range(0, 2) == 0) chr_read = ~chr_read;
            paused     = ($urandom_range(0, 7) == 0);
            ss_load    = ($urandom_range(0, 79) == 0);
            ss_din     = {$urandom, $urandom};
            chr_ram_en = 1'($urandom_range(0, 1));
            #1;
            check_outputs("rnd");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
